// File: rtl/cpu_mem_arbiter.sv
// Serializes the core's instruction-fetch and data-memory requests onto one
// single-ported bus, data access first, stalling the core until both complete.
module cpu_mem_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IM_ren,
  input  logic [31:0] IM_raddr,
  output logic [31:0] IM_rdata,
  input  logic        DM_ren,
  input  logic [3:0]  DM_wen,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] DM_rdata,
  output logic        waiting,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DM_ACC = 2'd1,
    IM_ACC = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

  state_t      state_r, state_nx_s;
  logic        dm_wr_s, dm_any_s, any_req_s, capture_s;
  logic        acc_s, expire_s, done_s;
  logic [31:0] im_addr_r, dm_addr_r, dm_wdata_r;
  logic [3:0]  dm_wen_r;
  logic        dm_wr_r, im_pend_r;
  logic [31:0] im_addr_nx_s, dm_addr_nx_s, dm_wdata_nx_s;
  logic [3:0]  dm_wen_nx_s;
  logic        dm_wr_nx_s, im_pend_nx_s;
  logic [7:0]  tmo_cnt_r;

  assign dm_wr_s   = (DM_wen != 4'hF);
  assign dm_any_s  = dm_wr_s | DM_ren;
  assign any_req_s = IM_ren | dm_any_s;
  assign capture_s = (state_r == IDLE) && any_req_s;
  assign acc_s     = (state_r == DM_ACC) || (state_r == IM_ACC);
  // An ack in the final allowed cycle takes precedence over the abort.
  assign expire_s  = acc_s && !mem_ack && (tmo_cnt_r == TMO_LAST);
  assign done_s    = acc_s && (mem_ack || expire_s);
  assign waiting   = !rst && (capture_s || acc_s);

  // Next-state selection and next values of the request latches.
  always_comb begin
    state_nx_s    = state_r;
    im_addr_nx_s  = im_addr_r;
    dm_addr_nx_s  = dm_addr_r;
    dm_wdata_nx_s = dm_wdata_r;
    dm_wen_nx_s   = dm_wen_r;
    dm_wr_nx_s    = dm_wr_r;
    im_pend_nx_s  = im_pend_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nx_s    = dm_any_s ? DM_ACC : IM_ACC;
          im_addr_nx_s  = IM_raddr;
          dm_addr_nx_s  = DM_addr;
          dm_wdata_nx_s = DM_wdata;
          dm_wen_nx_s   = DM_wen;
          dm_wr_nx_s    = dm_wr_s;
          im_pend_nx_s  = IM_ren;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DM_ACC: begin
        if (done_s) begin
          state_nx_s = im_pend_r ? IM_ACC : DONE;
        end else begin
          state_nx_s = DM_ACC;
        end
      end
      IM_ACC: begin
        if (done_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = IM_ACC;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, request latches and the registered bus drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      im_addr_r  <= 32'd0;
      dm_addr_r  <= 32'd0;
      dm_wdata_r <= 32'd0;
      dm_wen_r   <= 4'hF;
      dm_wr_r    <= 1'b0;
      im_pend_r  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 4'hF;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      state_r    <= state_nx_s;
      im_addr_r  <= im_addr_nx_s;
      dm_addr_r  <= dm_addr_nx_s;
      dm_wdata_r <= dm_wdata_nx_s;
      dm_wen_r   <= dm_wen_nx_s;
      dm_wr_r    <= dm_wr_nx_s;
      im_pend_r  <= im_pend_nx_s;
      mem_req    <= (state_nx_s == DM_ACC) || (state_nx_s == IM_ACC);
      mem_we     <= ((state_nx_s == DM_ACC) && dm_wr_nx_s) ? dm_wen_nx_s : 4'hF;
      mem_addr   <= (state_nx_s == IM_ACC) ? im_addr_nx_s : dm_addr_nx_s;
      mem_wdata  <= dm_wdata_nx_s;
    end
  end

  // Per-access wait counter, restarted whenever a new access state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_nx_s != state_r) begin
      tmo_cnt_r <= 8'd0;
    end else if (acc_s) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Read-data capture, abort pulse and stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      IM_rdata  <= 32'd0;
      DM_rdata  <= 32'd0;
      bus_err   <= 1'b0;
      stall_cnt <= 32'd0;
    end else begin
      if ((state_r == DM_ACC) && done_s && !dm_wr_r) begin
        DM_rdata <= mem_ack ? mem_rdata : ERR_RDATA;
      end else begin
        DM_rdata <= DM_rdata;
      end
      if ((state_r == IM_ACC) && done_s) begin
        IM_rdata <= mem_ack ? mem_rdata : ERR_RDATA;
      end else begin
        IM_rdata <= IM_rdata;
      end
      bus_err   <= expire_s;
      stall_cnt <= waiting ? (stall_cnt + 32'd1) : stall_cnt;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized bench for cpu_mem_arbiter against a transaction-level model of
// the expected bus sequence, stall counts and returned data.
module tb_cpu_mem_arbiter;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        IM_ren;
  logic [31:0] IM_raddr;
  logic [31:0] IM_rdata;
  logic        DM_ren;
  logic [3:0]  DM_wen;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [31:0] DM_rdata;
  logic        waiting;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic [31:0] stall_cnt;

  cpu_mem_arbiter #(.TIMEOUT(TMO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .IM_ren(IM_ren), .IM_raddr(IM_raddr), .IM_rdata(IM_rdata),
    .DM_ren(DM_ren), .DM_wen(DM_wen), .DM_addr(DM_addr), .DM_wdata(DM_wdata),
    .DM_rdata(DM_rdata), .waiting(waiting),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_im    = 32'd0;
  logic [31:0] exp_dm    = 32'd0;
  logic [31:0] exp_stall = 32'd0;
  logic        exp_err   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core inputs are ignored outside IDLE, so drive noise there.
  task automatic scramble();
    IM_ren    = 1'($urandom);
    DM_ren    = 1'($urandom);
    DM_wen    = 4'($urandom);
    IM_raddr  = $urandom;
    DM_addr   = $urandom;
    DM_wdata  = $urandom;
    mem_rdata = $urandom;
  endtask

  // One bus access: acks after w wait cycles unless the timeout comes first.
  task automatic do_access(input string tag, input logic [31:0] addr, input logic [3:0] we,
                           input logic [31:0] wdata, input int w, input logic [31:0] rdata,
                           output logic timed_out);
    int dur;
    dur       = (w + 1 < TMO) ? w + 1 : TMO;
    timed_out = (w + 1 > TMO);
    for (int c = 0; c < dur; c++) begin
      @(negedge clk);
      scramble();
      mem_ack   = (c == w);
      mem_rdata = rdata;
      #1;
      check_val({tag, "_req"}, 32'(mem_req), 32'd1);
      check_val({tag, "_addr"}, mem_addr, addr);
      check_val({tag, "_we"}, 32'(mem_we), 32'(we));
      if (we != 4'hF) check_val({tag, "_wdata"}, mem_wdata, wdata);
      check_val({tag, "_waiting"}, 32'(waiting), 32'd1);
      check_val({tag, "_bus_err"}, 32'(bus_err), 32'(exp_err));
      exp_err   = 1'b0;
      exp_stall = exp_stall + 32'd1;
    end
    exp_err = timed_out;
  endtask

  task automatic run_txn(input logic im, input logic dren, input logic [3:0] wen,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw,
                         input int wd, input int wi, input logic [31:0] rdd, input logic [31:0] rdi);
    logic dwr, dany, to;
    dwr  = (wen != 4'hF);
    dany = dwr | dren;
    @(negedge clk);
    IM_ren = im; DM_ren = dren; DM_wen = wen;
    IM_raddr = ia; DM_addr = da; DM_wdata = dw;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    check_val("idle_waiting", 32'(waiting), 32'(im | dany));
    check_val("idle_req", 32'(mem_req), 32'd0);
    check_val("idle_bus_err", 32'(bus_err), 32'(exp_err));
    exp_err = 1'b0;
    if (!(im | dany)) return;
    exp_stall = exp_stall + 32'd1;
    if (dany) begin
      do_access("dm", da, dwr ? wen : 4'hF, dw, wd, rdd, to);
      if (!dwr) exp_dm = to ? ERR : rdd;
    end
    if (im) begin
      do_access("im", ia, 4'hF, 32'd0, wi, rdi, to);
      exp_im = to ? ERR : rdi;
    end
    @(negedge clk);
    scramble();
    mem_ack = 1'b0;
    #1;
    check_val("done_waiting", 32'(waiting), 32'd0);
    check_val("done_req", 32'(mem_req), 32'd0);
    check_val("done_bus_err", 32'(bus_err), 32'(exp_err));
    exp_err = 1'b0;
    check_val("IM_rdata", IM_rdata, exp_im);
    check_val("DM_rdata", DM_rdata, exp_dm);
    check_val("stall_cnt", stall_cnt, exp_stall);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_req"}, 32'(mem_req), 32'd0);
    check_val({tag, "_waiting"}, 32'(waiting), 32'd0);
    check_val({tag, "_we"}, 32'(mem_we), 32'hF);
    check_val({tag, "_addr"}, mem_addr, 32'd0);
    check_val({tag, "_wdata"}, mem_wdata, 32'd0);
    check_val({tag, "_IM_rdata"}, IM_rdata, 32'd0);
    check_val({tag, "_DM_rdata"}, DM_rdata, 32'd0);
    check_val({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    check_val({tag, "_stall"}, stall_cnt, 32'd0);
  endtask

  initial begin
    logic [3:0] wen;
    rst = 1'b1;
    IM_ren = 1'b1; IM_raddr = 32'h0000_0040; DM_ren = 1'b0; DM_wen = 4'hF;
    DM_addr = 32'd0; DM_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("reset");

    @(negedge clk);
    rst = 1'b0; IM_ren = 1'b0;
    #1;
    check_val("post_reset_waiting", 32'(waiting), 32'd0);
    check_val("post_reset_req", 32'(mem_req), 32'd0);

    // Directed scenarios: fetch only, fetch+load, store with wait states,
    // fetch timeout, ack on the timeout cycle, load timeout.
    run_txn(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 32'h00A0_0093);
    run_txn(1'b1, 1'b1, 4'hF, 32'h104, 32'h8000, 32'h0, 0, 0, 32'h1122_3344, 32'h0000_0013);
    run_txn(1'b1, 1'b1, 4'b1100, 32'h108, 32'h8004, 32'hDEAD_BEEF, 3, 0, 32'h5555_AAAA, 32'h0000_0033);
    run_txn(1'b1, 1'b0, 4'hF, 32'h10C, 32'h0, 32'h0, 0, 50, 32'h0, 32'hCAFE_F00D);
    run_txn(1'b1, 1'b0, 4'hF, 32'h110, 32'h0, 32'h0, 0, TMO - 1, 32'h0, 32'h1234_5678);
    run_txn(1'b1, 1'b1, 4'hF, 32'h114, 32'h9000, 32'h0, 9, 1, 32'hFFFF_0000, 32'h0BAD_C0DE);
    run_txn(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Reset while the data access is stalled on the bus.
    @(negedge clk);
    IM_ren = 1'b1; DM_ren = 1'b1; DM_wen = 4'hF; DM_addr = 32'hA000; IM_raddr = 32'h200;
    mem_ack = 1'b0;
    #1;
    check_val("mid_idle_waiting", 32'(waiting), 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check_val("mid_dm_req", 32'(mem_req), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    IM_ren = 1'b0; DM_ren = 1'b0; DM_wen = 4'hF;
    #1;
    check_reset_state("mid_reset");
    rst = 1'b0;
    exp_im = 32'd0; exp_dm = 32'd0; exp_stall = 32'd0; exp_err = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check_val("after_reset_req", 32'(mem_req), 32'd0);
      check_val("after_reset_bus_err", 32'(bus_err), 32'd0);
    end

    for (int t = 0; t < 150; t++) begin
      wen = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      run_txn(1'($urandom), 1'($urandom), wen, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Sequencer that shares one single-ported memory bus between the CPU's instruction-fetch port and data-memory port. It sits between the CPU core and the bus/SRAM interface. It captures the IM and DM requests the core presents in a cycle and serializes them onto the bus, DM first. It drives the core's `waiting` stall input until both accesses have completed.

## Interface
Parameters:
- `TIMEOUT`, 255: max cycles an access may wait for `mem_ack` before it is aborted (1..255).
- `ERR_RDATA`, 32'h0000_0013: read data returned on an aborted access (NOP encoding).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `IM_ren`  in  1  core fetch request.
- `IM_raddr`  in  32  fetch address.
- `IM_rdata`  out  32  fetched instruction, registered.
- `DM_ren`  in  1  core load request.
- `DM_wen`  in  4  per-byte write strobes, active-low; 4'hF means no write.
- `DM_addr`  in  32  data address.
- `DM_wdata`  in  32  store data.
- `DM_rdata`  out  32  load data, registered.
- `waiting`  out  1  stall to core; high freezes all core pipeline registers.
- `mem_req`  out  1  bus request, registered.
- `mem_we`  out  4  bus byte strobes, active-low (4'hF = read).
- `mem_addr`  out  32  bus address.
- `mem_wdata`  out  32  bus write data.
- `mem_ack`  in  1  transfer completes in any cycle with `mem_req & mem_ack`.
- `mem_rdata`  in  32  read data, valid in the ack cycle.
- `bus_err`  out  1  one-cycle pulse when an access times out.
- `stall_cnt`  out  32  count of cycles with `waiting`=1; wraps.

## Operation
- Definitions: `dm_wr = (DM_wen != 4'hF)`; `dm_any = dm_wr | DM_ren`; `any_req = IM_ren | dm_any`.
- States: IDLE, DM_ACC, IM_ACC, DONE.
- IDLE: if `any_req`, latch `IM_raddr`, `DM_addr`, `DM_wdata`, `DM_wen`, the `dm_wr` type, and the IM/DM pending flags. Next state is DM_ACC if `dm_any`, else IM_ACC. With no request, stay in IDLE.
- DM_ACC: `mem_req`=1, `mem_addr`=latched DM addr.
  - Write: `mem_we`=latched `DM_wen`, `mem_wdata`=latched data.
  - Read: `mem_we`=4'hF.
  - Priority: a write takes priority when the strobes and `DM_ren` are both active; no read is performed.
  - On ack: for a read, `DM_rdata`<=`mem_rdata`; a write leaves `DM_rdata` unchanged. Next state is IM_ACC if IM is pending, else DONE.
- IM_ACC: `mem_req`=1, `mem_we`=4'hF, `mem_addr`=latched IM addr. On ack: `IM_rdata`<=`mem_rdata`, next state DONE.
- DONE: `waiting`=0 for exactly one cycle so the core advances; next state IDLE. `IM_rdata`/`DM_rdata` hold until overwritten by a later access.
- `waiting` is combinational: `(state==IDLE & any_req) | state==DM_ACC | state==IM_ACC`. It is 0 in DONE, and 0 whenever `rst`=1.
- Timeout:
  - An 8-bit counter clears on entry to DM_ACC or IM_ACC and increments each cycle of that state without ack.
  - When the counter reaches `TIMEOUT` with no ack, the access completes as if acked. Read data is `ERR_RDATA`, or no update for a write, and `bus_err` pulses in the following cycle.
  - An ack that arrives in the same cycle as the timeout wins: real data is used and there is no `bus_err`.
- `stall_cnt` increments by 1 every cycle `waiting`=1 and wraps at 2^32.
- `mem_req`=0 in IDLE and DONE. Address, data and strobes are don't-care when `mem_req`=0 but are driven from the latches; no X on outputs.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 4'hF, `mem_addr`/`mem_wdata` 0, `IM_rdata`/`DM_rdata` 0, `bus_err` 0, `stall_cnt` 0, timeout counter 0.
- Reset mid-access: next cycle is IDLE, `mem_req` drops, and the pending access is discarded with no `bus_err`.
- Zero-wait bus (ack in first request cycle):
  - IM+DM: IDLE(capture) → DM_ACC → IM_ACC → DONE = 4 cycles per core step, `waiting` high for 3.
  - IM only: 3 cycles, `waiting` high for 2.
- Each additional wait state on the bus adds one cycle.
- Inputs are sampled only in IDLE; changes during DM_ACC, IM_ACC or DONE are ignored.
- Back-to-back: the request is evaluated again in the cycle after DONE.

## Test plan
- Reset then IM_ren=1, IM_raddr=0x100, zero-wait bus, mem_rdata=0x00A00093 → `mem_req` at cycle 1 with addr 0x100, `IM_rdata`=0x00A00093, `waiting` pattern 1,1,0.
- IM 0x104 plus load DM_addr=0x8000, mem_rdata 0x11223344 then 0x00000013 → DM access precedes IM, `DM_rdata`=0x11223344, `waiting` 1,1,1,0.
- Store DM_wen=4'b1100 with DM_ren=1, DM_wdata=0xDEADBEEF, ack after 3 wait cycles → `mem_we`=4'b1100, wdata 0xDEADBEEF, `DM_rdata` unchanged, `stall_cnt`+=6 (IDLE, 4 DM_ACC cycles, 1 IM_ACC cycle; the IM_ACC cycle assumes IM_ren was also asserted).
- IM fetch with `mem_ack` never asserted, TIMEOUT=4 → abort after 4 cycles, `IM_rdata`=0x00000013, `bus_err` single pulse, state returns to IDLE via DONE.
- Ack on the exact timeout cycle → real data captured, `bus_err` stays 0.
- `rst` asserted during DM_ACC → `mem_req`=0 and `waiting`=0 next cycle, outputs at reset values, no `bus_err`.
